// File: rtl/onchip_mem_streamer_pkg.sv
// Shared types and defaults for the on-chip RAM read streamer.
// The entry struct fixes the stream data width at DATA_W_DFLT.
package onchip_mem_streamer_pkg;

    localparam int MEM_DEPTH_DFLT  = 3072;
    localparam int FIFO_DEPTH_DFLT = 4;
    localparam int DATA_W_DFLT     = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    typedef struct packed {
        logic                   last;
        logic [DATA_W_DFLT-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/onchip_mem_streamer_stream_fifo.sv
// Small synchronous FIFO with first-word-fall-through output, occupancy count
// and a flush that empties it in one edge. DEPTH must be a power of two.
module stream_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign do_push  = push & (count != CNT_W'(DEPTH));
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/onchip_mem_streamer.sv
// Avalon-MM read master streaming a contiguous run of on-chip RAM words to a
// valid/ready sink. Define ONCHIP_MEM_STREAMER_LOOP_EN to enable looped runs.
module onchip_mem_streamer
    import onchip_mem_streamer_pkg::*;
#(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = DATA_W_DFLT,
    parameter int MEM_DEPTH  = MEM_DEPTH_DFLT,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DFLT,
    parameter int LEN_W      = 13
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    input  logic              abort,
    input  logic              loop,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [3:0]        mem_byteenable,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic [DATA_W-1:0] st_data,
    output logic              st_valid,
    input  logic              st_ready,
    output logic              st_last
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  remain_q;
    logic              inflight_q;
    logic              inflight_last_q;
    logic              zero_done_q;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W:0]    occupancy;
    logic              fifo_empty;
    logic              accept;
    logic              issue;
    logic              last_issue;
    logic              reload;
    logic              drained;
    fifo_entry_t       push_entry;
    fifo_entry_t       head;
    logic [$bits(fifo_entry_t)-1:0] pop_data;

    assign mem_write      = 1'b0;
    assign mem_byteenable = 4'hF;
    assign mem_clken      = 1'b1;
    assign mem_address    = addr_q;

    // Counting the in-flight read as occupied is what keeps the FIFO from overflowing.
    assign occupancy  = {1'b0, fifo_count} + (CNT_W + 1)'(inflight_q);
    assign accept     = (state_q == IDLE) & start & ~abort;
    assign issue      = (state_q == RUN) & (remain_q != '0) & (occupancy < (CNT_W + 1)'(FIFO_DEPTH));
    assign last_issue = issue & (remain_q == LEN_W'(1));
    assign drained    = (state_q == DRAIN) & ~inflight_q & fifo_empty;

`ifdef ONCHIP_MEM_STREAMER_LOOP_EN
    logic [ADDR_W-1:0] base_q;
    logic [LEN_W-1:0]  len_q;

    assign reload = last_issue & loop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base_q <= '0;
            len_q  <= '0;
        end else if (accept) begin
            base_q <= base_addr;
            len_q  <= length;
        end
    end
`else
    logic unused_loop;
    assign unused_loop = loop;
    assign reload      = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (accept && length != '0) state_d = RUN;
                RUN:     if (last_issue && !reload) state_d = DRAIN;
                DRAIN:   if (drained) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Abort discards the outstanding response so a stale word never reaches the FIFO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q          <= '0;
            remain_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            zero_done_q     <= 1'b0;
        end else begin
            zero_done_q     <= accept & (length == '0);
            inflight_q      <= issue & ~abort;
            inflight_last_q <= last_issue & ~abort;
            if (accept) begin
                addr_q   <= base_addr;
                remain_q <= length;
            end else if (issue && !abort) begin
`ifdef ONCHIP_MEM_STREAMER_LOOP_EN
                if (reload) begin
                    addr_q   <= base_q;
                    remain_q <= len_q;
                end else begin
                    addr_q   <= (addr_q == ADDR_W'(MEM_DEPTH - 1)) ? '0 : addr_q + ADDR_W'(1);
                    remain_q <= remain_q - LEN_W'(1);
                end
`else
                addr_q   <= (addr_q == ADDR_W'(MEM_DEPTH - 1)) ? '0 : addr_q + ADDR_W'(1);
                remain_q <= remain_q - LEN_W'(1);
`endif
            end
        end
    end

    assign push_entry = '{last: inflight_last_q, data: mem_readdata};
    assign head       = fifo_entry_t'(pop_data);

    stream_fifo #(
        .WIDTH ($bits(fifo_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (abort),
        .push      (inflight_q),
        .push_data (push_entry),
        .pop       (st_valid & st_ready),
        .pop_data  (pop_data),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    always_comb begin
        busy           = (state_q != IDLE);
        done           = (drained & ~abort) | zero_done_q;
        mem_chipselect = issue;
        st_valid       = ~fifo_empty;
        st_data        = fifo_empty ? '0 : head.data;
        st_last        = ~fifo_empty & head.last;
    end

endmodule

// File: tb/tb_onchip_mem_streamer.sv
// Self-checking bench for onchip_mem_streamer with a 1-cycle-latency RAM model.
// Covers ONCHIP_MEM_STREAMER_LOOP_EN when that macro is defined.
module tb_onchip_mem_streamer;
    import onchip_mem_streamer_pkg::*;

    localparam int ADDR_W     = 12;
    localparam int DATA_W     = 32;
    localparam int LEN_W      = 13;
    localparam int MEM_DEPTH  = 3072;
    localparam int FIFO_DEPTH = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [LEN_W-1:0]  length;
    logic              abort;
    logic              loop;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_chipselect;
    logic              mem_write;
    logic [3:0]        mem_byteenable;
    logic              mem_clken;
    logic [DATA_W-1:0] mem_readdata = '0;
    logic [DATA_W-1:0] st_data;
    logic              st_valid;
    logic              st_ready;
    logic              st_last;

    onchip_mem_streamer dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .base_addr      (base_addr),
        .length         (length),
        .abort          (abort),
        .loop           (loop),
        .busy           (busy),
        .done           (done),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_byteenable (mem_byteenable),
        .mem_clken      (mem_clken),
        .mem_readdata   (mem_readdata),
        .st_data        (st_data),
        .st_valid       (st_valid),
        .st_ready       (st_ready),
        .st_last        (st_last)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ram_word(input logic [11:0] a);
        return 32'hC0DE_0000 ^ {a, 4'h0, a, 4'h5};
    endfunction

    always @(posedge clk) begin
        if (mem_chipselect) mem_readdata <= ram_word(mem_address);
    end

    typedef struct {
        logic [11:0] base;
        int          len;
        int          rdy_lo;
        int          rdy_hi;
        int          bump;
        int          exp_done;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } word_t;

    word_t       word_q[$];
    logic [11:0] addr_q[$];
    int          checks = 0;
    int          errors = 0;
    int          issued;
    int          taken;
    logic        stall_q;
    logic [31:0] stall_data;
    logic        stall_last;
    vec_t        vecs[8];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pushExpected(input logic [11:0] base, input int len);
        logic [11:0] a;
        a = base;
        for (int i = 0; i < len; i++) begin
            addr_q.push_back(a);
            word_q.push_back('{data: ram_word(a), last: (i == len - 1)});
            a = (a == 12'(MEM_DEPTH - 1)) ? 12'h000 : a + 12'h001;
        end
    endtask

    // Called once per cycle at the falling edge: requests, transfers and hold-stability.
    task automatic monitorCycle(input bit check_stream, output bit got_done);
        word_t w;
        got_done = done;
        if (mem_chipselect) begin
            issued++;
            if (addr_q.size() == 0) checkOutput("spurious_req", mem_chipselect, 1'b0);
            else                    checkOutput("req_addr", mem_address, addr_q.pop_front());
            checkOutput("buffer_bound", (issued - taken) <= FIFO_DEPTH, 1'b1);
        end
        if (check_stream && stall_q) begin
            checkOutput("hold_valid", st_valid, 1'b1);
            checkOutput("hold_word", {st_last, st_data}, {stall_last, stall_data});
        end
        if (check_stream && st_valid && st_ready) begin
            taken++;
            if (word_q.size() == 0) begin
                checkOutput("spurious_word", st_valid, 1'b0);
            end else begin
                w = word_q.pop_front();
                checkOutput("st_data", st_data, w.data);
                checkOutput("st_last", st_last, w.last);
            end
        end
        stall_q    = st_valid & ~st_ready;
        stall_data = st_data;
        stall_last = st_last;
    endtask

    task automatic applyStimulus(input vec_t v);
        int done_cyc;
        bit d;
        done_cyc = -1;
        issued   = 0;
        taken    = 0;
        stall_q  = 1'b0;
        pushExpected(v.base, v.len);
        @(posedge clk); #1;
        start     = 1'b1;
        base_addr = v.base;
        length    = LEN_W'(v.len);
        st_ready  = !(0 >= v.rdy_lo && 0 <= v.rdy_hi);
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            monitorCycle(1'b1, d);
            if (c == 0) checkOutput("busy_at_start", busy, 1'b0);
            if (v.exp_done >= 0 && c >= 1 && c <= v.exp_done + 1)
                checkOutput("busy", busy, (v.len != 0 && c <= v.exp_done));
            if (d && done_cyc < 0) begin
                done_cyc = c;
            end else if (done_cyc >= 0) begin
                checkOutput("done_width", done, 1'b0);
                checkOutput("idle_after_done", busy, 1'b0);
                break;
            end
            @(posedge clk); #1;
            start     = (c + 1 == v.bump);
            base_addr = 12'h000;
            length    = LEN_W'(5);
            st_ready  = !(c + 1 >= v.rdy_lo && c + 1 <= v.rdy_hi);
        end
        start    = 1'b0;
        st_ready = 1'b1;
        if (v.exp_done >= 0) checkOutput("done_cycle", done_cyc, v.exp_done);
        else                 checkOutput("done_seen", done_cyc >= 0, 1'b1);
        checkOutput("words_left", word_q.size(), 0);
        checkOutput("reqs_left", addr_q.size(), 0);
        word_q.delete();
        addr_q.delete();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit d;
        int done_cyc;
        reset     = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        st_ready  = 1'b1;
        base_addr = '0;
        length    = '0;
`ifdef ONCHIP_MEM_STREAMER_LOOP_EN
        loop = 1'b0;
`else
        loop = 1'b1;
`endif
        vecs[0] = '{12'h010,  3, -1, -1, -1,  6};
        vecs[1] = '{12'hBFE,  4, -1, -1, -1,  7};
        vecs[2] = '{12'hBFF,  2, -1, -1, -1,  5};
        vecs[3] = '{12'h000,  1, -1, -1, -1,  4};
        vecs[4] = '{12'h100,  0, -1, -1, -1,  1};
        vecs[5] = '{12'h123,  8,  2, 12, -1, -1};
        vecs[6] = '{12'h300,  4, -1, -1,  2,  7};
        vecs[7] = '{12'h7F0, 16, -1, -1, -1, 19};

        #12;
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_cs", mem_chipselect, 1'b0);
        checkOutput("rst_addr", mem_address, 12'h000);
        checkOutput("rst_stream", {st_valid, st_last, st_data}, 34'h0);
        checkOutput("const_pins", {mem_write, mem_byteenable, mem_clken}, 6'b0_1111_1);
        #20 reset = 1'b0;

        for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

        // Abort mid-run: no done, stream empties, stale response ignored.
        issued  = 0;
        taken   = 0;
        stall_q = 1'b0;
        pushExpected(12'h200, 100);
        @(posedge clk); #1;
        start     = 1'b1;
        base_addr = 12'h200;
        length    = LEN_W'(100);
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            monitorCycle(c < 10, d);
            if (c >= 10) checkOutput("abort_no_done", done, 1'b0);
            if (c >= 11) begin
                checkOutput("abort_valid", st_valid, 1'b0);
                checkOutput("abort_busy", busy, 1'b0);
                checkOutput("abort_cs", mem_chipselect, 1'b0);
            end
            @(posedge clk); #1;
            start = 1'b0;
            abort = (c + 1 == 10);
        end
        word_q.delete();
        addr_q.delete();
        applyStimulus('{12'h050, 3, -1, -1, -1, 6});

        // Asynchronous reset in the middle of a run.
        @(posedge clk); #1;
        start     = 1'b1;
        base_addr = 12'h400;
        length    = LEN_W'(20);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("midrst_busy", busy, 1'b0);
        checkOutput("midrst_cs", mem_chipselect, 1'b0);
        checkOutput("midrst_stream", {st_valid, st_last, st_data, done}, 35'h0);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus('{12'h0A0, 2, -1, -1, -1, 5});

`ifdef ONCHIP_MEM_STREAMER_LOOP_EN
        // Three passes over two words, then loop drops and the run completes.
        issued   = 0;
        taken    = 0;
        stall_q  = 1'b0;
        done_cyc = -1;
        loop     = 1'b1;
        for (int p = 0; p < 3; p++) pushExpected(12'h020, 2);
        @(posedge clk); #1;
        start     = 1'b1;
        base_addr = 12'h020;
        length    = LEN_W'(2);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            monitorCycle(1'b1, d);
            if (d) begin
                done_cyc = c;
                break;
            end
            @(posedge clk); #1;
            start = 1'b0;
            loop  = (c + 1 < 6);
        end
        checkOutput("loop_done_cycle", done_cyc, 9);
        checkOutput("loop_words_left", word_q.size(), 0);
        checkOutput("loop_reqs_left", addr_q.size(), 0);
        word_q.delete();
        addr_q.delete();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/onchip_mem_streamer.md
Name: onchip_mem_streamer

Overview:
- Avalon-MM read master that sits directly upstream of the 3072x32 single-port on-chip RAM, on its s1 port.
- On a start command it reads a contiguous run of words starting at a base address.
- Words are presented on a valid/ready stream to downstream multimedia sinks (audio DAC, sprite or palette loader).
- A small prefetch FIFO absorbs the RAM's fixed 1-cycle read latency and downstream backpressure.

Parameters:
- ADDR_W, 12, word-address width of the RAM port.
- DATA_W, 32, data width.
- MEM_DEPTH, 3072, number of valid words; addresses wrap at this value.
- FIFO_DEPTH, 4, prefetch entries; power of two, minimum 2.
- LEN_W, 13, width of the length field; must be able to hold MEM_DEPTH.

Ports:
- clk  in  1  single clock for the whole block.
- reset  in  1  asynchronous, active-high.
- start  in  1  one-cycle command strobe; ignored while busy.
- base_addr  in  ADDR_W  first word address; sampled on an accepted start.
- length  in  LEN_W  number of words to read; sampled on an accepted start.
- abort  in  1  terminate the current run.
- loop  in  1  restart from base_addr after the last word (optional feature only).
- busy  out  1  high from the cycle after an accepted start until return to IDLE.
- done  out  1  one-cycle pulse when a run completes normally.
- mem_address  out  ADDR_W  RAM word address.
- mem_chipselect  out  1  read request.
- mem_write  out  1  constant 0.
- mem_byteenable  out  4  constant 4'hF.
- mem_clken  out  1  constant 1.
- mem_readdata  in  DATA_W  RAM data, valid exactly 1 cycle after the request.
- st_data  out  DATA_W  stream word.
- st_valid  out  1  stream word valid.
- st_ready  in  1  sink ready.
- st_last  out  1  marks the final word of a run.

Behaviour:
- Reset values: busy=0, done=0, mem_chipselect=0, mem_address=0, st_valid=0, st_last=0, st_data=0. FIFO is empty, state is IDLE.
- States and transitions:
  - IDLE: start=1 latches base_addr and length into addr_q and remain_q; next state RUN.
  - IDLE with start=1 and length=0: no reads are issued; done pulses the next cycle; state stays IDLE; busy stays 0.
  - RUN: a read is issued in a cycle (mem_chipselect=1, mem_address=addr_q) iff remain_q!=0 and fifo_count + inflight < FIFO_DEPTH. inflight is 0 or 1.
  - RUN, per issued read: addr_q = (addr_q==MEM_DEPTH-1) ? 0 : addr_q+1, and remain_q decrements.
  - RUN -> DRAIN once the last read has been issued.
  - DRAIN: when inflight=0 and the FIFO is empty, pulse done, go to IDLE, drop busy.
- Read capture: mem_readdata is written into the FIFO on the clock edge ending the cycle after the request. The FIFO can never overflow, because of the issue rule.
- Latency: start in cycle 0, first request in cycle 1, FIFO write at the end of cycle 2, st_valid=1 in cycle 3.
- Peak throughput is 1 word/cycle with st_ready held high.
- Stream rules:
  - A word transfers when st_valid & st_ready.
  - st_data, st_valid and st_last are held stable while st_valid & ~st_ready.
  - Each FIFO entry carries a last flag, set on the word whose request decremented remain_q to 0.
- Simultaneous FIFO push and pop keeps fifo_count unchanged.
- Abort, in any state: on the next edge the FIFO is flushed, st_valid=0, inflight is discarded (the in-flight read response is ignored), and state goes to IDLE. done is not pulsed. If start is also asserted in the same cycle, abort wins.
- start while busy is ignored. No error is flagged.
- Reset asserted mid-run returns all outputs to their reset values immediately (asynchronous).

Optional Feature:
- Macro: ONCHIP_MEM_STREAMER_LOOP_EN.
- Defined: when the last word's request issues while loop=1, addr_q reloads base_addr and remain_q reloads the latched length. State stays RUN, and no done pulse is generated. st_last still marks each pass's final word. Deasserting loop lets the current pass finish normally.
- Undefined: the loop input is ignored and the reload logic is absent.

Decomposition:
- Package onchip_mem_streamer_pkg holds:
  - the state enum (IDLE, RUN, DRAIN);
  - MEM_DEPTH and FIFO_DEPTH defaults;
  - a fifo entry struct {last, data}.
- One sub-module, stream_fifo: synchronous FIFO with count output, flush input and first-word-fall-through output. It is instantiated once.

Test Plan:
- Single run: base=0x010, length=3, st_ready=1 -> requests to 0x010, 0x011, 0x012 in cycles 1-3; st_valid cycles 3-5; st_last only with the word from 0x012; done pulse cycle 6.
- Wrap: base=0xBFE, length=4 -> addresses 0xBFE, 0xBFF, 0x000, 0x001.
- Backpressure: length=8 with st_ready low for cycles 2-12 -> at most 4 words buffered, no more than 4 requests issued, data order preserved, no word lost or duplicated.
- Zero length: start with length=0 -> no mem_chipselect, done 1 cycle later, busy stays 0.
- Abort: length=100, abort in cycle 10 -> IDLE next cycle, st_valid=0, no done; a new start 2 cycles later runs cleanly from its own base.
- Loop (macro defined): base=0x020, length=2, loop=1 for 3 passes -> address sequence 0x020, 0x021, 0x020, 0x021, ...; st_last every second word; done only after loop is dropped.
